// File: rtl/brg_xcel_pkg.sv
`default_nettype none
// ============================================================================
// Package  : brg_xcel_pkg
// Brief    : Shared state encoding and command record for the xcel master/slave
//            request logic.
// Revision : 1.0
// ============================================================================
package brg_xcel_pkg;

    // Command fields are held at their widest supported size; each engine
    // instance zero-extends its own narrower fields into them.
    localparam int CMD_CORD_W  = 16;
    localparam int CMD_ADDR_W  = 64;
    localparam int CMD_DATA_W  = 64;
    localparam int CMD_COUNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic                   we;
        logic [CMD_CORD_W-1:0]  x;
        logic [CMD_CORD_W-1:0]  y;
        logic [CMD_ADDR_W-1:0]  addr;
        logic [CMD_DATA_W-1:0]  data;
        logic [CMD_COUNT_W-1:0] count;
    } cmd_s;

endpackage
`default_nettype wire

// File: rtl/brg_master_ret_accum.sv
`default_nettype none
// ============================================================================
// Module   : brg_master_ret_accum
// Brief    : Counts in-order load returns, sums their data, flags id mismatch.
// Revision : 1.0
// ============================================================================
module brg_master_ret_accum #(
    parameter int data_width_p    = 32,
    parameter int load_id_width_p = 11,
    parameter int count_width_p   = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       active_i,
    input  logic                       returned_v_i,
    input  logic [data_width_p-1:0]    returned_data_i,
    input  logic [load_id_width_p-1:0] returned_load_id_i,
    output logic [count_width_p-1:0]   ret_cnt_o,
    output logic [data_width_p-1:0]    sum_o,
    output logic                       id_err_o
);

    logic [count_width_p-1:0] ret_cnt_q, ret_cnt_d;
    logic [data_width_p-1:0]  sum_q, sum_d;
    logic                     id_err_q, id_err_d;
    logic                     w_take;

    assign w_take = returned_v_i & active_i;

    always_comb begin
        ret_cnt_d = ret_cnt_q;
        sum_d     = sum_q;
        id_err_d  = id_err_q;
        if (clear_i) begin
            ret_cnt_d = '0;
            sum_d     = '0;
        end else if (w_take) begin
            ret_cnt_d = ret_cnt_q + count_width_p'(1);
            sum_d     = sum_q + returned_data_i;
            // Returns arrive in issue order, so the expected id is the return index.
            if (returned_load_id_i != load_id_width_p'(ret_cnt_q)) begin
                id_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ret_cnt_q <= '0;
            sum_q     <= '0;
            id_err_q  <= 1'b0;
        end else begin
            ret_cnt_q <= ret_cnt_d;
            sum_q     <= sum_d;
            id_err_q  <= id_err_d;
        end
    end

    assign ret_cnt_o = ret_cnt_q;
    assign sum_o     = sum_q;
    assign id_err_o  = id_err_q;

endmodule
`default_nettype wire

// File: rtl/brg_master_req_engine.sv
`default_nettype none
// ============================================================================
// Module   : brg_master_req_engine
// Brief    : Issues a burst of remote load/store requests, waits for all credits,
//            and pulses done with the summed load data.
//            Define BRG_MASTER_REQ_TRACE_EN for a simulation trace.
// Revision : 1.0
// ============================================================================
module brg_master_req_engine
    import brg_xcel_pkg::*;
#(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int load_id_width_p   = 11,
    parameter int max_out_credits_p = 200,
    parameter int count_width_p     = 16
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     cmd_v_i,
    output logic                                     cmd_ready_o,
    input  logic                                     cmd_we_i,
    input  logic [x_cord_width_p-1:0]                cmd_x_i,
    input  logic [y_cord_width_p-1:0]                cmd_y_i,
    input  logic [addr_width_p-1:0]                  cmd_addr_i,
    input  logic [data_width_p-1:0]                  cmd_data_i,
    input  logic [count_width_p-1:0]                 cmd_count_i,
    output logic                                     out_v_o,
    input  logic                                     out_ready_i,
    output logic                                     out_we_o,
    output logic [addr_width_p-1:0]                  out_addr_o,
    output logic [data_width_p-1:0]                  out_data_o,
    output logic [data_width_p/8-1:0]                out_mask_o,
    output logic [x_cord_width_p-1:0]                out_x_o,
    output logic [y_cord_width_p-1:0]                out_y_o,
    output logic [load_id_width_p-1:0]               out_load_id_o,
    input  logic                                     returned_v_i,
    input  logic [data_width_p-1:0]                  returned_data_i,
    input  logic [load_id_width_p-1:0]               returned_load_id_i,
    input  logic [$clog2(max_out_credits_p+1)-1:0]   out_credits_i,
    output logic                                     done_v_o,
    output logic [data_width_p-1:0]                  done_sum_o,
    output logic                                     id_err_o
);

    localparam int c_CREDIT_W = $clog2(max_out_credits_p + 1);

    state_e                   state_q, state_d;
    cmd_s                     cmd_q, cmd_d;
    logic [count_width_p-1:0] idx_q, idx_d;
    logic                     done_v_q, done_v_d;
    logic [data_width_p-1:0]  done_sum_q, done_sum_d;

    logic                     w_we;
    logic [addr_width_p-1:0]  w_base;
    logic [data_width_p-1:0]  w_seed;
    logic [count_width_p-1:0] w_count;
    logic                     w_fire;
    logic                     w_credits_full;
    logic                     w_load_active;
    logic                     w_accum_clear;
    logic [count_width_p-1:0] w_ret_cnt;
    logic [data_width_p-1:0]  w_sum;
    logic                     w_unused_cmd;

    assign w_we    = cmd_q.we;
    assign w_base  = cmd_q.addr[addr_width_p-1:0];
    assign w_seed  = cmd_q.data[data_width_p-1:0];
    assign w_count = cmd_q.count[count_width_p-1:0];
    // Upper bits of the widest-case command record are always zero here.
    assign w_unused_cmd = ^cmd_q;

    assign w_fire         = out_v_o & out_ready_i;
    assign w_credits_full = (out_credits_i == c_CREDIT_W'(max_out_credits_p));
    assign w_load_active  = (state_q != IDLE) & ~w_we;

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        idx_d         = idx_q;
        done_v_d      = 1'b0;
        done_sum_d    = done_sum_q;
        w_accum_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_v_i) begin
                    cmd_d.we      = cmd_we_i;
                    cmd_d.x       = CMD_CORD_W'(cmd_x_i);
                    cmd_d.y       = CMD_CORD_W'(cmd_y_i);
                    cmd_d.addr    = CMD_ADDR_W'(cmd_addr_i);
                    cmd_d.data    = CMD_DATA_W'(cmd_data_i);
                    cmd_d.count   = CMD_COUNT_W'(cmd_count_i);
                    idx_d         = '0;
                    w_accum_clear = 1'b1;
                    state_d       = (cmd_count_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (w_fire) begin
                    idx_d = idx_q + count_width_p'(1);
                    if (idx_q == w_count - count_width_p'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_credits_full && (w_we || (w_ret_cnt == w_count))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_v_d   = 1'b1;
                done_sum_d = w_sum;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            idx_q      <= '0;
            done_v_q   <= 1'b0;
            done_sum_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            done_v_q   <= done_v_d;
            done_sum_q <= done_sum_d;
        end
    end

    brg_master_ret_accum #(
        .data_width_p    (data_width_p),
        .load_id_width_p (load_id_width_p),
        .count_width_p   (count_width_p)
    ) u_ret_accum (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .clear_i            (w_accum_clear),
        .active_i           (w_load_active),
        .returned_v_i       (returned_v_i),
        .returned_data_i    (returned_data_i),
        .returned_load_id_i (returned_load_id_i),
        .ret_cnt_o          (w_ret_cnt),
        .sum_o              (w_sum),
        .id_err_o           (id_err_o)
    );

    // Request fields depend only on registered state, so they hold under backpressure.
    assign cmd_ready_o   = (state_q == IDLE);
    assign out_v_o       = (state_q == ISSUE) && (out_credits_i != '0);
    assign out_we_o      = w_we;
    assign out_addr_o    = w_base + addr_width_p'(idx_q);
    assign out_data_o    = w_seed + data_width_p'(idx_q);
    assign out_mask_o    = '1;
    assign out_x_o       = cmd_q.x[x_cord_width_p-1:0];
    assign out_y_o       = cmd_q.y[y_cord_width_p-1:0];
    assign out_load_id_o = load_id_width_p'(idx_q);
    assign done_v_o      = done_v_q;
    assign done_sum_o    = done_sum_q;

`ifdef BRG_MASTER_REQ_TRACE_EN
    logic [31:0] trace_cycle_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            trace_cycle_q <= '0;
        end else begin
            trace_cycle_q <= trace_cycle_q + 32'd1;
            if (w_fire) begin
                $display("[brg_req] fire x=%0d y=%0d addr=0x%0h we=%0b data=0x%0h id=%0d",
                         out_x_o, out_y_o, out_addr_o, out_we_o, out_data_o, out_load_id_o);
            end
            if (returned_v_i && w_load_active) begin
                $display("[brg_req] return id=%0d data=0x%0h", returned_load_id_i, returned_data_i);
            end
            if (state_q == DONE) begin
                $display("[brg_req] done sum=0x%0h cycle=%0d", w_sum, trace_cycle_q);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_brg_master_req_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_brg_master_req_engine
// Brief    : Self-checking bench with an endpoint/memory model for the engine.
// Revision : 1.0
// ============================================================================
module tb_brg_master_req_engine;

    localparam int XW   = 4;
    localparam int YW   = 3;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int LIDW = 4;
    localparam int MAXC = 200;
    localparam int CW   = 16;
    localparam int CRW  = $clog2(MAXC + 1);

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            cmd_v_i;
    logic            cmd_ready_o;
    logic            cmd_we_i;
    logic [XW-1:0]   cmd_x_i;
    logic [YW-1:0]   cmd_y_i;
    logic [AW-1:0]   cmd_addr_i;
    logic [DW-1:0]   cmd_data_i;
    logic [CW-1:0]   cmd_count_i;
    logic            out_v_o;
    logic            out_ready_i;
    logic            out_we_o;
    logic [AW-1:0]   out_addr_o;
    logic [DW-1:0]   out_data_o;
    logic [DW/8-1:0] out_mask_o;
    logic [XW-1:0]   out_x_o;
    logic [YW-1:0]   out_y_o;
    logic [LIDW-1:0] out_load_id_o;
    logic            returned_v_i;
    logic [DW-1:0]   returned_data_i;
    logic [LIDW-1:0] returned_load_id_i;
    logic [CRW-1:0]  out_credits_i;
    logic            done_v_o;
    logic [DW-1:0]   done_sum_o;
    logic            id_err_o;

    always #5 clk_i = ~clk_i;

    brg_master_req_engine #(
        .x_cord_width_p    (XW),
        .y_cord_width_p    (YW),
        .data_width_p      (DW),
        .addr_width_p      (AW),
        .load_id_width_p   (LIDW),
        .max_out_credits_p (MAXC),
        .count_width_p     (CW)
    ) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .cmd_v_i            (cmd_v_i),
        .cmd_ready_o        (cmd_ready_o),
        .cmd_we_i           (cmd_we_i),
        .cmd_x_i            (cmd_x_i),
        .cmd_y_i            (cmd_y_i),
        .cmd_addr_i         (cmd_addr_i),
        .cmd_data_i         (cmd_data_i),
        .cmd_count_i        (cmd_count_i),
        .out_v_o            (out_v_o),
        .out_ready_i        (out_ready_i),
        .out_we_o           (out_we_o),
        .out_addr_o         (out_addr_o),
        .out_data_o         (out_data_o),
        .out_mask_o         (out_mask_o),
        .out_x_o            (out_x_o),
        .out_y_o            (out_y_o),
        .out_load_id_o      (out_load_id_o),
        .returned_v_i       (returned_v_i),
        .returned_data_i    (returned_data_i),
        .returned_load_id_i (returned_load_id_i),
        .out_credits_i      (out_credits_i),
        .done_v_o           (done_v_o),
        .done_sum_o         (done_sum_o),
        .id_err_o           (id_err_o)
    );

    // Endpoint model: in-flight requests return in order after a random latency.
    typedef struct {
        int unsigned     due;
        logic            we;
        logic [AW-1:0]   addr;
        logic [LIDW-1:0] id;
    } pend_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] seed;
        logic [CW-1:0] count;
        logic [DW-1:0] exp_sum;
    } vec_t;

    pend_t         pend[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          exp_idx = 0;
    int          fires = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    int          ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 4;

    logic          e_we = 1'b0;
    logic [XW-1:0] e_x = '0;
    logic [YW-1:0] e_y = '0;
    logic [AW-1:0] e_base = '0;
    logic [DW-1:0] e_seed = '0;
    int            e_count = 0;

    logic block_credits = 1'b0;
    logic ready_force = 1'b1;
    logic ready_val = 1'b1;
    logic corrupt_next = 1'b0;

    logic            s_out_v;
    logic            s_done_v;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_data;
    logic [LIDW-1:0] s_id;
    logic [DW-1:0]   last_done_sum = '0;

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DW-1:0] exp_load_sum(input logic [AW-1:0] base, input int count);
        logic [DW-1:0] s;
        logic [AW-1:0] a;
        s = '0;
        for (int i = 0; i < count; i++) begin
            a = base + AW'(i);
            s = s + memval(a);
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, then cross the posedge.
    task automatic tick();
        logic            ret_now;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ed;
        logic [LIDW-1:0] eid;
        ret_now            = 1'b0;
        returned_v_i       = 1'b0;
        returned_data_i    = '0;
        returned_load_id_i = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            ret_now = 1'b1;
            if (!pend[0].we) begin
                returned_v_i       = 1'b1;
                returned_data_i    = memval(pend[0].addr);
                returned_load_id_i = corrupt_next ? ~pend[0].id : pend[0].id;
                corrupt_next       = 1'b0;
            end
        end
        out_credits_i = block_credits ? '0 : CRW'(MAXC - pend.size());
        out_ready_i   = ready_force ? ready_val : (int'($urandom_range(0, 99)) < ready_pct);
        #1;
        s_out_v  = out_v_o;
        s_done_v = done_v_o;
        s_addr   = out_addr_o;
        s_data   = out_data_o;
        s_id     = out_load_id_o;
        if (out_credits_i == '0) chk("v_with_zero_credit", 64'(out_v_o), 64'(0));
        if (out_v_o && out_ready_i) begin
            ea  = e_base + AW'(exp_idx);
            ed  = e_seed + DW'(exp_idx);
            eid = LIDW'(exp_idx);
            chk("fire_addr", 64'(out_addr_o), 64'(ea));
            chk("fire_data", 64'(out_data_o), 64'(ed));
            chk("fire_id", 64'(out_load_id_o), 64'(eid));
            chk("fire_hdr", 64'({out_we_o, out_x_o, out_y_o, out_mask_o}),
                64'({e_we, e_x, e_y, 4'hF}));
            pend.push_back('{due: cyc + $urandom_range(lat_min, lat_max), we: e_we, addr: ea, id: eid});
            exp_idx++;
            fires++;
        end
        if (ret_now) void'(pend.pop_front());
        if (done_v_o) begin
            done_cnt++;
            last_done_sum = done_sum_o;
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic start_cmd(input logic we, input logic [XW-1:0] x, input logic [YW-1:0] y,
                             input logic [AW-1:0] addr, input logic [DW-1:0] seed, input int count);
        int b;
        b = 0;
        while (!cmd_ready_o && b < 2000) begin
            tick();
            b++;
        end
        chk("cmd_ready_before_cmd", 64'(cmd_ready_o), 64'(1));
        e_we = we; e_x = x; e_y = y; e_base = addr; e_seed = seed; e_count = count;
        exp_idx = 0; fires = 0; done_base = done_cnt;
        cmd_v_i = 1'b1; cmd_we_i = we; cmd_x_i = x; cmd_y_i = y;
        cmd_addr_i = addr; cmd_data_i = seed; cmd_count_i = CW'(count);
        tick();
        cmd_v_i = 1'b0;
    endtask

    task automatic finish_cmd(input logic [DW-1:0] exp_sum, input string name);
        int b;
        b = 0;
        while (done_cnt == done_base && b < 400 + 30 * e_count) begin
            tick();
            b++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt - done_base), 64'(1));
        chk({name, "_fires"}, 64'(fires), 64'(e_count));
        chk({name, "_sum"}, 64'(last_done_sum), 64'(exp_sum));
        tick();
        chk({name, "_pulse_one_cycle"}, 64'(s_done_v), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        vec_t            vt [5];
        logic [AW-1:0]   cap_addr;
        logic [DW-1:0]   cap_data;
        logic [LIDW-1:0] cap_id;
        logic            rwe;
        logic [AW-1:0]   raddr;
        int              rcnt;
        int              b;

        vt[0] = '{1'b1, 32'h0000_0100, 32'h0000_0010, 16'd4,  32'd0};
        vt[1] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 16'd3,  32'd21};
        vt[2] = '{1'b0, 32'h0000_0300, 32'h0000_0000, 16'd17, 32'd153};
        vt[3] = '{1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 16'd4,  32'd0};
        vt[4] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 16'd0,  32'd0};
        mem[32'h200] = 32'd5;
        mem[32'h201] = 32'd7;
        mem[32'h202] = 32'd9;
        for (int i = 0; i < 17; i++) mem[32'h300 + 32'(i)] = 32'(i + 1);

        reset_i = 1'b1; cmd_v_i = 1'b0; cmd_we_i = 1'b0; cmd_x_i = '0; cmd_y_i = '0;
        cmd_addr_i = '0; cmd_data_i = '0; cmd_count_i = '0; out_ready_i = 1'b0;
        returned_v_i = 1'b0; returned_data_i = '0; returned_load_id_i = '0;
        out_credits_i = CRW'(MAXC);
        @(negedge clk_i);
        repeat (3) tick();
        reset_i = 1'b0;
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
        chk("rst_out_v", 64'(out_v_o), 64'(0));
        chk("rst_done_v", 64'(done_v_o), 64'(0));
        chk("rst_done_sum", 64'(done_sum_o), 64'(0));
        chk("rst_id_err", 64'(id_err_o), 64'(0));

        // Directed vectors, endpoint always ready.
        ready_force = 1'b1; ready_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_cmd(vt[i].we, 4'h5, 3'h2, vt[i].addr, vt[i].seed, int'(vt[i].count));
            finish_cmd(vt[i].exp_sum, $sformatf("vec%0d", i));
        end
        chk("table_id_err", 64'(id_err_o), 64'(0));

        // count==0: DONE state in the cycle after accept, pulse in the one after that.
        start_cmd(1'b0, 4'h1, 3'h1, 32'h0000_0A00, 32'h0, 0);
        tick();
        chk("cnt0_no_pulse_yet", 64'(s_done_v), 64'(0));
        tick();
        chk("cnt0_pulse", 64'(s_done_v), 64'(1));
        chk("cnt0_sum", 64'(last_done_sum), 64'(0));
        tick();
        chk("cnt0_pulse_end", 64'(s_done_v), 64'(0));

        // Credits withheld mid-issue.
        lat_min = 3; lat_max = 5;
        start_cmd(1'b0, 4'h3, 3'h4, 32'h0000_0400, 32'h0, 8);
        b = 0;
        while (exp_idx < 3 && b < 100) begin tick(); b++; end
        block_credits = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("blk_out_v", 64'(s_out_v), 64'(0));
        end
        block_credits = 1'b0;
        tick();
        chk("blk_resume_v", 64'(s_out_v), 64'(1));
        finish_cmd(exp_load_sum(32'h400, 8), "credit_block");

        // Backpressure: fields must hold, index must not advance.
        start_cmd(1'b1, 4'h7, 3'h5, 32'h0000_0500, 32'h0000_0055, 6);
        b = 0;
        while (exp_idx < 2 && b < 100) begin tick(); b++; end
        ready_val = 1'b0;
        tick();
        cap_addr = s_addr; cap_data = s_data; cap_id = s_id;
        chk("stall_v", 64'(s_out_v), 64'(1));
        chk("stall_addr_idx", 64'(cap_addr), 64'(32'h502));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_v_hold", 64'(s_out_v), 64'(1));
            chk("stall_fields", 64'({s_addr, s_data, s_id}), 64'({cap_addr, cap_data, cap_id}));
        end
        ready_val = 1'b1;
        finish_cmd(32'd0, "ready_stall");

        // Randomized commands against the memory model.
        ready_force = 1'b0;
        for (int r = 0; r < 12; r++) begin
            rwe       = 1'($urandom_range(0, 1));
            rcnt      = int'($urandom_range(1, 40));
            raddr     = $urandom();
            ready_pct = int'($urandom_range(40, 100));
            lat_min   = 1;
            lat_max   = int'($urandom_range(1, 10));
            start_cmd(rwe, XW'($urandom()), YW'($urandom()), raddr, $urandom(), rcnt);
            finish_cmd(rwe ? 32'd0 : exp_load_sum(raddr, rcnt), $sformatf("rand%0d", r));
        end
        chk("rand_id_err", 64'(id_err_o), 64'(0));

        // Wrong id on the first return sets the sticky error.
        ready_force = 1'b1; ready_val = 1'b1; lat_min = 1; lat_max = 4;
        corrupt_next = 1'b1;
        start_cmd(1'b0, 4'h2, 3'h3, 32'h0000_0800, 32'h0, 4);
        finish_cmd(exp_load_sum(32'h800, 4), "bad_id");
        chk("bad_id_err", 64'(id_err_o), 64'(1));

        // Reset during DRAIN, then stale returns arrive while idle.
        lat_min = 40; lat_max = 40;
        start_cmd(1'b0, 4'h6, 3'h6, 32'h0000_0900, 32'h0, 4);
        b = 0;
        while (exp_idx < 4 && b < 100) begin tick(); b++; end
        repeat (3) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
        chk("mid_rst_out_v", 64'(out_v_o), 64'(0));
        chk("mid_rst_done_v", 64'(done_v_o), 64'(0));
        chk("mid_rst_done_sum", 64'(done_sum_o), 64'(0));
        chk("mid_rst_id_err", 64'(id_err_o), 64'(0));
        lat_min = 1; lat_max = 4;
        b = 0;
        while (pend.size() > 0 && b < 200) begin tick(); b++; end
        chk("stale_ret_id_err", 64'(id_err_o), 64'(0));
        chk("stale_ret_ready", 64'(cmd_ready_o), 64'(1));
        start_cmd(1'b0, 4'h4, 3'h1, 32'h0000_0B00, 32'h0, 5);
        finish_cmd(exp_load_sum(32'hB00, 5), "post_reset");
        chk("post_reset_id_err", 64'(id_err_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
